// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RISCV32I instruction fetch stage.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          FETCH_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instr}; flush wins over push, a pop in the flush
// cycle is simply absorbed by the flush.
module fetch_buffer
  import riscv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem_q [FETCH_DEPTH];
  fetch_entry_t mem_d [FETCH_DEPTH];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'(FETCH_DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & ~empty;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      for (int i = 0; i < FETCH_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited pipelined
// requests to a variable-latency memory and feeds decode from a 2-entry buffer.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  Instr,
  output logic [31:0]  PC,
  output logic [31:0]  PC_4,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic         fetch_fault,
  output fetch_state_e dbg_state
);

  // Handshakes: a request completes on imem_req & imem_gnt, a response on
  // imem_rvalid (in order), and decode consumes on instr_valid & instr_ready.

  fetch_state_e state_q, state_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   discard_q, discard_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  logic         fault_q, fault_d;

  logic         consume;
  logic [2:0]   credit_used;
  logic         gnt_fire;
  logic         rsp_fire;
  logic         rsp_keep;
  logic         buf_push;
  logic         buf_full;
  logic         buf_empty;
  logic [1:0]   buf_count;
  fetch_entry_t buf_head;
  fetch_entry_t push_entry;

  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata};

  fetch_buffer u_fetch_buffer (
    .clk        (CLK),
    .rst        (rst),
    .push       (buf_push),
    .push_entry (push_entry),
    .pop        (consume),
    .flush      (redirect),
    .full       (buf_full),
    .empty      (buf_empty),
    .count      (buf_count),
    .head       (buf_head)
  );

  // With the buffer empty, PC shows the address of the next word to arrive.
  assign instr_valid = ~buf_empty;
  assign Instr       = buf_empty ? NOP_INSTR : buf_head.instr;
  assign PC          = buf_empty ? rsp_pc_q : buf_head.pc;
  assign PC_4        = PC + 32'd4;
  assign imem_addr   = fetch_pc_q;
  assign fetch_fault = fault_q;
  assign dbg_state   = state_q;

  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    fault_d       = fault_q;

    consume     = instr_valid & instr_ready;
    // Slots already promised: in flight plus buffered, minus the word leaving now.
    credit_used = {1'b0, outstanding_q} + {1'b0, buf_count} - {2'b00, consume};
    imem_req    = (state_q == RUN) & ~redirect & (credit_used < 3'(FETCH_DEPTH));
    gnt_fire    = imem_req & imem_gnt;
    rsp_fire    = imem_rvalid & (outstanding_q != 2'd0);
    rsp_keep    = rsp_fire & (discard_q == 2'd0) & ~redirect;
    buf_push    = rsp_keep & (~buf_full | consume);

    outstanding_d = outstanding_q + {1'b0, gnt_fire} - {1'b0, rsp_fire};

    if (gnt_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (rsp_keep) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH: begin
        if (rsp_fire && discard_q != 2'd0) begin
          discard_d = discard_q - 2'd1;
          if (discard_q == 2'd1) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = BOOT;
    endcase

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect) begin
      discard_d  = outstanding_d;
      state_d    = (outstanding_d != 2'd0) ? FLUSH : RUN;
      fetch_pc_d = align_word(redirect_target);
      rsp_pc_d   = align_word(redirect_target);
      if (redirect_target[1:0] != 2'b00) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: boot vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_instr_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic         CLK = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  Instr;
  logic [31:0]  PC;
  logic [31:0]  PC_4;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [31:0]  redirect_target;
  logic         fetch_fault;
  fetch_state_e dbg_state;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK             (CLK),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .Instr           (Instr),
    .PC              (PC),
    .PC_4            (PC_4),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .dbg_state       (dbg_state)
  );

  always #5 CLK = ~CLK;

  // Memory: every granted request is answered in order, with its own latency.
  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  typedef struct {
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  vec_t        boot_vec[10];

  int          checks, failures, cyc, epoch, last_due;
  int          lat_min, lat_max, gnt_pct;
  bit          boot, exp_fault, cur_consume, cur_fire;
  logic [31:0] exp_fetch_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A03;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rdy, input bit redir, input logic [31:0] tgt);
    instr_ready     = rdy;
    redirect        = redir;
    redirect_target = tgt;
    imem_gnt        = ($urandom_range(0, 99) < 32'(gnt_pct));
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
  endtask

  task automatic model_check();
    bit           stale, consume, exp_req;
    int           used;
    fetch_state_e exp_state;
    stale     = (mem_q.size() != 0) && (mem_q[0].epoch != epoch);
    consume   = (exp_q.size() != 0) && instr_ready;
    used      = mem_q.size() + exp_q.size() - (consume ? 1 : 0);
    exp_req   = !boot && !stale && !redirect && (used < 2);
    exp_state = boot ? BOOT : (stale ? FLUSH : RUN);
    check32("imem_req", imem_req, exp_req);
    check32("imem_addr", imem_addr, exp_fetch_pc);
    check32("instr_valid", instr_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check32("pc", PC, exp_q[0]);
      check32("pc_4", PC_4, exp_q[0] + 32'd4);
      check32("instr", Instr, mem_word(exp_q[0]));
    end else begin
      check32("instr_nop", Instr, NOP_INSTR);
    end
    check32("fetch_fault", fetch_fault, exp_fault);
    check32("state", 32'(dbg_state), 32'(exp_state));
    cur_consume = consume;
    cur_fire    = imem_req & imem_gnt;
  endtask

  task automatic advance();
    mem_req_t r;
    int       d;
    if (cur_consume) void'(exp_q.pop_front());
    if (imem_rvalid) begin
      r = mem_q.pop_front();
      if (r.epoch == epoch && !redirect) exp_q.push_back(r.addr);
    end
    if (cur_fire) begin
      d = cyc + int'($urandom_range(lat_max, lat_min));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{addr: imem_addr, due: d, epoch: epoch});
      exp_fetch_pc = exp_fetch_pc + 32'd4;
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      exp_fetch_pc = {redirect_target[31:2], 2'b00};
      if (redirect_target[1:0] != 2'b00) exp_fault = 1'b1;
    end
    boot = 1'b0;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
    drive(rdy, redir, tgt);
    model_check();
    advance();
  endtask

  // Called just after a rising edge; reset is raised between edges.
  task automatic do_reset();
    #2;
    rst             = 1'b1;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    imem_gnt        = 1'b0;
    imem_rvalid     = 1'b0;
    #1;
    check32("rst_req", imem_req, 1'b0);
    check32("rst_addr", imem_addr, RST_PC);
    check32("rst_valid", instr_valid, 1'b0);
    check32("rst_instr", Instr, NOP_INSTR);
    check32("rst_pc", PC, RST_PC);
    check32("rst_pc_4", PC_4, RST_PC + 32'd4);
    check32("rst_fault", fetch_fault, 1'b0);
    check32("rst_state", 32'(dbg_state), 32'(BOOT));
    mem_q.delete();
    exp_q.delete();
    epoch++;
    boot         = 1'b1;
    exp_fault    = 1'b0;
    exp_fetch_pc = RST_PC;
    @(posedge CLK);
    #1;
    cyc++;
    last_due = cyc;
    rst      = 1'b0;
  endtask

  task automatic run_boot_table();
    lat_min = 1;
    lat_max = 1;
    gnt_pct = 100;
    for (int i = 0; i < 10; i++) begin
      drive(boot_vec[i].rdy, 1'b0, 32'h0);
      check32($sformatf("vec%0d_req", i), imem_req, boot_vec[i].exp_req);
      check32($sformatf("vec%0d_addr", i), imem_addr, boot_vec[i].exp_addr);
      check32($sformatf("vec%0d_valid", i), instr_valid, boot_vec[i].exp_valid);
      if (boot_vec[i].exp_valid) begin
        check32($sformatf("vec%0d_pc", i), PC, boot_vec[i].exp_pc);
        check32($sformatf("vec%0d_instr", i), Instr, mem_word(boot_vec[i].exp_pc));
      end
      model_check();
      advance();
    end
  endtask

  task automatic reach_two_outstanding();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_q.size() == 2 && mem_q[0].epoch == epoch) found = 1'b1;
      else step(1'b1, 1'b0, 32'h0);
    end
    check32("two_outstanding_reached", found, 1'b1);
  endtask

  initial begin
    int          t0, stale_last, n_flush;
    bit          seen_req, seen_valid;
    bit          rdy, rd;
    logic [31:0] tgt;

    rst = 1'b1;
    instr_ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    checks = 0; failures = 0; cyc = 0; epoch = 0; last_due = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    boot = 1'b1; exp_fault = 1'b0; exp_fetch_pc = RST_PC;
    cur_consume = 1'b0; cur_fire = 1'b0;

    // Latency 1, always granted: {ready, req, addr, valid, pc} per cycle.
    boot_vec[0] = '{1'b1, 1'b0, 32'h100, 1'b0, 32'h0};
    boot_vec[1] = '{1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
    boot_vec[2] = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
    boot_vec[3] = '{1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
    boot_vec[4] = '{1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
    boot_vec[5] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
    boot_vec[6] = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C};
    boot_vec[7] = '{1'b0, 1'b0, 32'h114, 1'b1, 32'h10C};
    boot_vec[8] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h10C};
    boot_vec[9] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h110};

    @(posedge CLK);
    #1;
    do_reset();
    run_boot_table();

    // Decode stalls for 5 cycles, then drains.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0);
      check32("stall_credit", (mem_q.size() + exp_q.size()) <= 2, 1'b1);
      model_check();
      advance();
    end
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'h0);

    // Redirect with two requests in flight at latency 3.
    lat_min = 3;
    lat_max = 3;
    reach_two_outstanding();
    t0         = cyc;
    stale_last = mem_q[mem_q.size() - 1].due;
    step(1'b1, 1'b1, 32'h200);
    n_flush = 0; seen_req = 1'b0; seen_valid = 1'b0;
    for (int k = 0; k < 14; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (dbg_state == FLUSH) n_flush++;
      if (!seen_req && imem_req && imem_gnt) begin
        seen_req = 1'b1;
        check32("redir_first_addr", imem_addr, 32'h200);
      end
      if (!seen_valid && instr_valid) begin
        seen_valid = 1'b1;
        check32("redir_first_pc", PC, 32'h200);
      end
      model_check();
      advance();
    end
    check32("flush_cycles", n_flush, stale_last - t0);
    check32("redir_req_seen", seen_req, 1'b1);
    check32("redir_valid_seen", seen_valid, 1'b1);

    // Redirect coinciding with an arriving word and a consume.
    lat_min = 1;
    lat_max = 1;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h300);
    check32("rv_consume_setup", imem_rvalid & instr_valid, 1'b1);
    model_check();
    advance();
    check32("flush_empty", instr_valid, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0);

    // Misaligned target raises the sticky fault and restarts aligned.
    step(1'b1, 1'b1, 32'h203);
    check32("fault_set", fetch_fault, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h400);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0);
    check32("fault_sticky", fetch_fault, 1'b1);

    // Address wrap at the top of the space.
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a flush, then a clean reboot.
    lat_min = 3;
    lat_max = 3;
    reach_two_outstanding();
    step(1'b1, 1'b1, 32'h240);
    check32("pre_reset_flush", 32'(dbg_state), 32'(FLUSH));
    do_reset();
    run_boot_table();

    // Randomized traffic.
    lat_min = 1;
    lat_max = 4;
    gnt_pct = 70;
    for (int i = 0; i < 2500; i++) begin
      rdy = ($urandom_range(0, 99) < 75);
      rd  = ($urandom_range(0, 99) < 4);
      tgt = $urandom_range(0, 32'h0000_0FFF);
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      step(rdy, rd, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
